ofm_convert_top: RTL and testbench

- Converts one layer-2 output row into one layer-3 input row.
- Takes two AXI-Stream bursts on 64-bit slave port S_AXIS_MM2S: burst A is channels 0-31, burst B is channels 32-63, each burst 256 pixels × 4 words.
- Crops the row to 208 pixels and emits 208 pixels × 8 words (all 64 channels, pixel-major) on master port M_AXIS_S2MM.
- Sits between the DMA MM2S and S2MM channels.

---
 rtl/ofm_convert_pkg.sv | 16 +
 rtl/ofm_convert_if.sv | 17 +
 rtl/ofm_conv_buf.sv | 33 +++
 rtl/ofm_convert.sv | 180 ++++++++++++++++++
 tb/tb_ofm_convert_top.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/ofm_convert_pkg.sv
// rtl/ofm_convert_pkg.sv - shared geometry defaults and state encoding for the row converter
package ofm_convert_pkg;

    localparam int TBITS    = 64;
    localparam int TBYTE    = 8;
    localparam int IN_COLS  = 256;
    localparam int OUT_COLS = 208;
    localparam int HALF_WPP = 4;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/ofm_convert_if.sv
// rtl/ofm_convert_if.sv - stream bundle (tvalid/tready/tdata/tkeep/tlast) with master/slave views
// Ports: none; the bundle is instantiated per stream and bound through modports.
//   master: drives tvalid, tdata, tkeep, tlast; receives tready
//   slave : receives tvalid, tdata, tkeep, tlast; drives tready
interface ofm_convert_if #(
    parameter int TBITS = 64,
    parameter int TBYTE = 8
) ();
    logic             tvalid;
    logic             tready;
    logic [TBITS-1:0] tdata;
    logic [TBYTE-1:0] tkeep;
    logic             tlast;

    modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/ofm_conv_buf.sv
// rtl/ofm_conv_buf.sv - simple dual-port synchronous RAM, one write and one read port
// Ports:
//   clk           : clock for both ports
//   we/waddr/wdata: write port, write on we
//   re/raddr      : read port, rdata registered one cycle after re
//   rdata         : read data
module ofm_conv_buf #(
    parameter int DEPTH = 832,
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset: contents are always written before they are read in a row.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ofm_convert.sv
// rtl/ofm_convert.sv - ofm_convert_top: merges two half-channel bursts into one cropped pixel-major row
// Ports:
//   aclk, aresetn      : clock, synchronous active-low reset
//   S_AXIS_MM2S_ACLK   : tied to aclk outside, unused
//   M_AXIS_S2MM_ACLK   : tied to aclk outside, unused
//   S_AXIS_MM2S (slave): burst A (ch 0-31) then burst B (ch 32-63), IN_COLS*HALF_WPP beats each
//   M_AXIS_S2MM (master): OUT_COLS*2*HALF_WPP words, tlast on the final word
module ofm_convert_top
    import ofm_convert_pkg::*;
#(
    parameter int TBITS    = ofm_convert_pkg::TBITS,
    parameter int TBYTE    = ofm_convert_pkg::TBYTE,
    parameter int IN_COLS  = ofm_convert_pkg::IN_COLS,
    parameter int OUT_COLS = ofm_convert_pkg::OUT_COLS,
    parameter int HALF_WPP = ofm_convert_pkg::HALF_WPP
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 S_AXIS_MM2S_ACLK,
    input  logic                 M_AXIS_S2MM_ACLK,
    ofm_convert_if.slave         S_AXIS_MM2S,
    ofm_convert_if.master        M_AXIS_S2MM
);

    localparam int IN_BEATS  = IN_COLS * HALF_WPP;
    localparam int BUF_WORDS = OUT_COLS * HALF_WPP;
    localparam int OUT_WORDS = 2 * BUF_WORDS;
    localparam int CNT_W     = $clog2(IN_BEATS);
    localparam int BUF_AW    = $clog2(BUF_WORDS);
    localparam int OUT_W     = $clog2(OUT_WORDS + 1);
    localparam int G_W       = $clog2(HALF_WPP);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(IN_BEATS - 1);
    localparam logic [CNT_W-1:0] KEEP_LIM  = CNT_W'(BUF_WORDS);
    localparam logic [OUT_W-1:0] K_END     = OUT_W'(OUT_WORDS);
    localparam logic [OUT_W-1:0] K_LAST    = OUT_W'(OUT_WORDS - 1);

    state_t state_q, state_d;

    logic [CNT_W-1:0] beat_cnt_q;
    logic             in_beat;
    logic             last_in_beat;
    logic             keep_beat;

    logic [OUT_W-1:0]  rd_k_q;
    logic [BUF_AW-1:0] rd_addr;
    logic              issue;
    logic              rd_pend_q, rd_sel_q, rd_last_q;
    logic [TBITS-1:0]  a_rdata, b_rdata, rd_data;

    logic             out_valid_q, out_last_q;
    logic [TBITS-1:0] out_data_q;
    logic             skid_valid_q, skid_last_q;
    logic [TBITS-1:0] skid_data_q;
    logic             pop;
    logic [1:0]       occ;

    logic unused_inputs;
    assign unused_inputs = ^{S_AXIS_MM2S_ACLK, M_AXIS_S2MM_ACLK, S_AXIS_MM2S.tkeep, S_AXIS_MM2S.tlast};

    // Input side: burst length is counted, tlast is never consulted.
    assign S_AXIS_MM2S.tready = aresetn && (state_q != DRAIN);
    assign in_beat            = S_AXIS_MM2S.tvalid && S_AXIS_MM2S.tready;
    assign last_in_beat       = in_beat && (beat_cnt_q == LAST_BEAT);
    assign keep_beat          = in_beat && (beat_cnt_q < KEEP_LIM);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_A:  if (last_in_beat) state_d = LOAD_B;
            LOAD_B:  if (last_in_beat) state_d = DRAIN;
            DRAIN:   if (pop && out_last_q) state_d = LOAD_A;
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            beat_cnt_q <= '0;
        end else if (in_beat) begin
            beat_cnt_q <= last_in_beat ? '0 : beat_cnt_q + 1'b1;
        end
    end

    // Output word k reads pixel k/(2*HALF_WPP), group k%HALF_WPP, from the half
    // picked by bit G_W of k: buffer address = {pixel, group}.
    assign rd_addr = BUF_AW'({rd_k_q[OUT_W-1:G_W+1], rd_k_q[G_W-1:0]});

    ofm_conv_buf #(.DEPTH(BUF_WORDS), .WIDTH(TBITS), .AW(BUF_AW)) u_buf_a (
        .clk   (aclk),
        .we    (keep_beat && (state_q == LOAD_A)),
        .waddr (beat_cnt_q[BUF_AW-1:0]),
        .wdata (S_AXIS_MM2S.tdata),
        .re    (issue),
        .raddr (rd_addr),
        .rdata (a_rdata)
    );

    ofm_conv_buf #(.DEPTH(BUF_WORDS), .WIDTH(TBITS), .AW(BUF_AW)) u_buf_b (
        .clk   (aclk),
        .we    (keep_beat && (state_q == LOAD_B)),
        .waddr (beat_cnt_q[BUF_AW-1:0]),
        .wdata (S_AXIS_MM2S.tdata),
        .re    (issue),
        .raddr (rd_addr),
        .rdata (b_rdata)
    );

    assign rd_data = rd_sel_q ? b_rdata : a_rdata;

    // Output register plus one skid slot give two words of storage. A read is
    // issued only if the word in flight will still have a slot when it lands,
    // which keeps one word per cycle flowing under continuous tready.
    assign pop = out_valid_q && M_AXIS_S2MM.tready;
    assign occ = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_pend_q};
    assign issue = (state_q == DRAIN) && (rd_k_q != K_END) && ((occ - {1'b0, pop}) < 2'd2);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_k_q <= '0;
        end else if (state_q != DRAIN) begin
            rd_k_q <= '0;
        end else if (issue) begin
            rd_k_q <= rd_k_q + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_pend_q    <= 1'b0;
            rd_sel_q     <= 1'b0;
            rd_last_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
        end else begin
            rd_pend_q <= issue;
            rd_sel_q  <= rd_k_q[G_W];
            rd_last_q <= (rd_k_q == K_LAST);
            if (!out_valid_q || pop) begin
                if (skid_valid_q) begin
                    out_valid_q  <= 1'b1;
                    out_data_q   <= skid_data_q;
                    out_last_q   <= skid_last_q;
                    skid_valid_q <= rd_pend_q;
                    skid_data_q  <= rd_data;
                    skid_last_q  <= rd_last_q;
                end else if (rd_pend_q) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= rd_data;
                    out_last_q  <= rd_last_q;
                end else begin
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end
            end else if (rd_pend_q) begin
                skid_valid_q <= 1'b1;
                skid_data_q  <= rd_data;
                skid_last_q  <= rd_last_q;
            end
        end
    end

    assign M_AXIS_S2MM.tvalid = out_valid_q;
    assign M_AXIS_S2MM.tdata  = out_data_q;
    assign M_AXIS_S2MM.tlast  = out_last_q;
    assign M_AXIS_S2MM.tkeep  = '1;

endmodule

// File: tb/tb_ofm_convert_top.sv
// tb/tb_ofm_convert_top.sv - scoreboard bench for ofm_convert_top
module tb_ofm_convert_top;

    localparam int NWORDS = 1664;
    localparam logic [63:0] MARKER = 64'hDEAD_BEEF_DEAD_BEEF;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    ofm_convert_if #(.TBITS(64), .TBYTE(8)) s_if ();
    ofm_convert_if #(.TBITS(64), .TBYTE(8)) m_if ();

    ofm_convert_top dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .S_AXIS_MM2S_ACLK (aclk),
        .M_AXIS_S2MM_ACLK (aclk),
        .S_AXIS_MM2S      (s_if),
        .M_AXIS_S2MM      (m_if)
    );

    int total = 0;
    int bad = 0;
    int frames_done = 0;
    int out_idx = 0;
    bit bp = 1'b0;
    logic [63:0] exp_q [$];
    bit          last_q [$];
    logic [63:0] cap [NWORDS];

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] word(input bit b, input int i);
        logic [15:0] i16;
        i16 = 16'(i);
        if (i >= 832) return MARKER;
        return {(b ? 16'hB000 : 16'hA000) + i16, 16'h0000, 16'hC0DE, i16};
    endfunction

    task automatic push_frame();
        for (int k = 0; k < NWORDS; k++) begin
            int p, j;
            p = k / 8;
            j = k % 8;
            exp_q.push_back(j < 4 ? word(1'b0, p*4 + j) : word(1'b1, p*4 + j - 4));
            last_q.push_back(k == NWORDS - 1);
        end
    endtask

    task automatic send_burst(input bit b, input bit gaps, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            int t;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    s_if.tvalid = 1'b0;
                    @(negedge aclk);
                end
            end
            s_if.tvalid = 1'b1;
            s_if.tdata  = word(b, i);
            s_if.tlast  = (i == 1023);
            t = 0;
            while (!s_if.tready && t < 100) begin
                @(negedge aclk);
                t++;
            end
            if (!s_if.tready || i == 0 || i == nbeats - 1)
                chk("s_tready_load", s_if.tready, 64'(s_if.tready), 64'd1);
            @(negedge aclk);
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
    endtask

    task automatic run_row(input bit gaps);
        send_burst(1'b0, gaps, 1024);
        send_burst(1'b1, gaps, 1024);
        push_frame();
    endtask

    task automatic wait_frames(input int n);
        int t;
        t = 0;
        while (frames_done < n && t < 20000) begin
            @(negedge aclk);
            t++;
        end
        chk("frame_timeout", frames_done >= n, 64'(frames_done), 64'(n));
    endtask

    // Downstream ready changes just after the active edge, so negedge samples are stable.
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            m_if.tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor / scoreboard.
    initial begin
        bit          prev_stall;
        bit          after_last;
        logic [63:0] prev_data;
        logic        prev_last;
        prev_stall = 1'b0;
        after_last = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                prev_stall = 1'b0;
                after_last = 1'b0;
                continue;
            end
            if (after_last) begin
                chk("s_tready_after_last", s_if.tready == 1'b1, 64'(s_if.tready), 64'd1);
                chk("m_tvalid_after_last", m_if.tvalid == 1'b0, 64'(m_if.tvalid), 64'd0);
                after_last = 1'b0;
            end
            if (prev_stall) begin
                chk("stall_hold", m_if.tvalid && m_if.tdata == prev_data && m_if.tlast == prev_last,
                    m_if.tdata, prev_data);
            end
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 1'b0, m_if.tdata, 64'd0);
                end else begin
                    logic [63:0] e;
                    bit          l;
                    e = exp_q.pop_front();
                    l = last_q.pop_front();
                    chk("data", m_if.tdata == e, m_if.tdata, e);
                    chk("tlast", m_if.tlast == l, 64'(m_if.tlast), 64'(l));
                end
                if (m_if.tdata == MARKER) chk("crop_marker", 1'b0, m_if.tdata, 64'd0);
                if (frames_done == 0 && out_idx < NWORDS) cap[out_idx] = m_if.tdata;
                out_idx++;
                if (m_if.tlast) begin
                    chk("frame_len", out_idx == NWORDS, 64'(out_idx), 64'(NWORDS));
                    chk("s_tready_drain", s_if.tready == 1'b0, 64'(s_if.tready), 64'd0);
                    out_idx = 0;
                    frames_done++;
                    after_last = 1'b1;
                end
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev_data  = m_if.tdata;
            prev_last  = m_if.tlast;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '1;
        s_if.tlast  = 1'b0;
        aresetn     = 1'b0;
        repeat (3) @(negedge aclk);
        chk("rst_m_tvalid", m_if.tvalid == 1'b0, 64'(m_if.tvalid), 64'd0);
        chk("rst_m_tdata", m_if.tdata == 64'd0, m_if.tdata, 64'd0);
        chk("rst_m_tlast", m_if.tlast == 1'b0, 64'(m_if.tlast), 64'd0);
        chk("rst_s_tready", s_if.tready == 1'b0, 64'(s_if.tready), 64'd0);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("post_rst_s_tready", s_if.tready == 1'b1, 64'(s_if.tready), 64'd1);
        chk("m_tkeep", m_if.tkeep == 8'hFF, 64'(m_if.tkeep), 64'hFF);

        // Row 1: nominal.
        run_row(1'b0);
        wait_frames(1);
        chk("out0",    cap[0]    == 64'hA000_0000_C0DE_0000, cap[0],    64'hA000_0000_C0DE_0000);
        chk("out3",    cap[3]    == 64'hA003_0000_C0DE_0003, cap[3],    64'hA003_0000_C0DE_0003);
        chk("out4",    cap[4]    == 64'hB000_0000_C0DE_0000, cap[4],    64'hB000_0000_C0DE_0000);
        chk("out7",    cap[7]    == 64'hB003_0000_C0DE_0003, cap[7],    64'hB003_0000_C0DE_0003);
        chk("out8",    cap[8]    == 64'hA004_0000_C0DE_0004, cap[8],    64'hA004_0000_C0DE_0004);
        chk("out1663", cap[1663] == 64'hB33F_0000_C0DE_033F, cap[1663], 64'hB33F_0000_C0DE_033F);

        // Row 2: random input gaps.
        run_row(1'b1);
        wait_frames(2);

        // Row 3: random downstream backpressure.
        bp = 1'b1;
        run_row(1'b0);
        wait_frames(3);
        bp = 1'b0;

        // Reset in the middle of burst B, then a fresh full row.
        send_burst(1'b0, 1'b0, 1024);
        send_burst(1'b1, 1'b0, 500);
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        chk("midrst_s_tready", s_if.tready == 1'b0, 64'(s_if.tready), 64'd0);
        aresetn = 1'b1;
        repeat (5) @(negedge aclk);
        chk("midrst_m_tvalid", m_if.tvalid == 1'b0, 64'(m_if.tvalid), 64'd0);
        chk("midrst_s_tready_back", s_if.tready == 1'b1, 64'(s_if.tready), 64'd1);
        run_row(1'b0);
        wait_frames(4);

        repeat (5) @(negedge aclk);
        chk("queue_empty", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
        chk("frames", frames_done == 4, 64'(frames_done), 64'd4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
